regfile_bist: RTL

- Built-in self-test initiator that drives the write port (we3/a3/wd3) and both read ports (a1/a2) of the 32x32 three-port register file, then checks the read data (rd1/rd2).
- Runs two write-then-read passes: a true pattern, then its inverse. Reports pass/fail, the first failing address and port, and an error count.
- Sits beside the register file. The top level muxes the regfile ports between the datapath and this block while busy=1.

---
 rtl/regfile_bist_if.sv | 37 +++
 rtl/regfile_bist.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_bist_if.sv
// ---------------------------------------------------------------------------
// regfile_bist_if
//   Port bundle between the register-file BIST initiator and the 32x32
//   three-port register file (one write port, two combinational read ports).
//
//   Signals:
//     we3  - write enable
//     a3   - write address
//     wd3  - write data
//     a1   - read address, port 1
//     a2   - read address, port 2
//     rd1  - read data, port 1 (combinational from a1)
//     rd2  - read data, port 2 (combinational from a2)
//
//   Modports:
//     master - the BIST side: drives addresses/write data, samples read data
//     slave  - the register-file side
// ---------------------------------------------------------------------------
interface regfile_bist_if;
  logic        we3;
  logic [4:0]  a3;
  logic [31:0] wd3;
  logic [4:0]  a1;
  logic [4:0]  a2;
  logic [31:0] rd1;
  logic [31:0] rd2;

  modport master (
    output we3, a3, wd3, a1, a2,
    input  rd1, rd2
  );

  modport slave (
    input  we3, a3, wd3, a1, a2,
    output rd1, rd2
  );
endinterface

// File: rtl/regfile_bist.sv
// ---------------------------------------------------------------------------
// regfile_bist
//   Built-in self-test initiator for the 32x32 three-port register file.
//   A run writes every register with a seed pattern (BASE + i), reads them
//   all back on both read ports (port 1 ascending, port 2 descending), then
//   repeats with the inverted pattern. r0 is hard-wired to zero, so it is
//   always expected to read back as 0.
//
//   Ports:
//     clk       - clock, rising-edge active
//     reset     - asynchronous, active-high reset
//     start     - run request, honoured only in IDLE
//     rf        - register-file bundle (master side): we3/a3/wd3/a1/a2 out,
//                 rd1/rd2 in
//     busy      - high from the first write cycle through the last read cycle
//     done      - one-cycle pulse at the end of a run
//     pass      - result of the last run, held until the next start
//     fail_addr - address of the first miscompare of the run
//     fail_port - port of the first miscompare (0 = rd1, 1 = rd2)
//     err_count - number of miscompares in the run
//
//   State table:
//     S_IDLE | waiting for start
//     S_WR   | writing pattern p to register idx, one per cycle
//     S_RD   | reading idx on port 1 and LAST-idx on port 2, comparing
//     S_DONE | one-cycle done pulse, back to S_IDLE
// ---------------------------------------------------------------------------
module regfile_bist #(
  parameter logic [31:0] BASE = 32'hA5A5_0000,
  parameter int          NREG = 32
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  regfile_bist_if.master rf,
  output logic           busy,
  output logic           done,
  output logic           pass,
  output logic [4:0]     fail_addr,
  output logic           fail_port,
  output logic [7:0]     err_count
);

  localparam logic [4:0] LAST = 5'(NREG - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WR   = 2'd1,
    S_RD   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [4:0]  idx;
  logic        pidx;
  logic [4:0]  idx_mirror;
  logic [31:0] exp1;
  logic [31:0] exp2;
  logic        miss1;
  logic        miss2;

  function automatic logic [31:0] pat(input logic p, input logic [4:0] k);
    logic [31:0] v;
    v = BASE + {27'd0, k};
    return p ? ~v : v;
  endfunction

  // r0 ignores writes and always reads as zero.
  function automatic logic [31:0] exp_val(input logic p, input logic [4:0] k);
    return (k == 5'd0) ? 32'd0 : pat(p, k);
  endfunction

  assign idx_mirror = LAST - idx;

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------
  // Next state and regfile-facing outputs. Everything here is decoded from
  // flopped state/idx/pidx only, so the write port is settled well before
  // the regfile's falling-edge write, and an async reset drops we3 at once.
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    rf.we3  = 1'b0;
    rf.a3   = 5'd0;
    rf.wd3  = 32'd0;
    rf.a1   = 5'd0;
    rf.a2   = 5'd0;
    busy    = 1'b0;
    done    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_WR;
        end
      end

      S_WR: begin
        busy   = 1'b1;
        rf.we3 = 1'b1;
        rf.a3  = idx;
        rf.wd3 = pat(pidx, idx);
        if (idx == LAST) begin
          state_d = S_RD;
        end
      end

      S_RD: begin
        busy  = 1'b1;
        rf.a1 = idx;
        rf.a2 = idx_mirror;
        if (idx == LAST) begin
          state_d = pidx ? S_DONE : S_WR;
        end
      end

      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Read-back comparison
  // ---------------------------------------------------------------------
  always_comb begin
    exp1  = exp_val(pidx, idx);
    exp2  = exp_val(pidx, idx_mirror);
    miss1 = (rf.rd1 != exp1);
    miss2 = (rf.rd2 != exp2);
  end

  // ---------------------------------------------------------------------
  // Counters and result registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx       <= 5'd0;
      pidx      <= 1'b0;
      pass      <= 1'b0;
      fail_addr <= 5'd0;
      fail_port <= 1'b0;
      err_count <= 8'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          idx <= 5'd0;
          if (start) begin
            pidx      <= 1'b0;
            pass      <= 1'b1;
            fail_addr <= 5'd0;
            fail_port <= 1'b0;
            err_count <= 8'd0;
          end
        end

        S_WR: begin
          // idx wraps LAST -> 0, which is exactly the clear for the read phase.
          idx <= idx + 5'd1;
        end

        S_RD: begin
          idx       <= idx + 5'd1;
          err_count <= err_count + {7'd0, miss1} + {7'd0, miss2};
          // pass is still 1 only until the first miscompare of the run, so it
          // doubles as the "nothing recorded yet" flag. Port 1 wins a tie.
          if (pass && (miss1 || miss2)) begin
            pass      <= 1'b0;
            fail_addr <= miss1 ? idx : idx_mirror;
            fail_port <= ~miss1;
          end
          if (idx == LAST) begin
            pidx <= 1'b1;
          end
        end

        S_DONE: begin
          idx <= 5'd0;
        end

        default: begin
          idx <= 5'd0;
        end
      endcase
    end
  end

endmodule
